// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment controller: register map,
// CTRL field positions and the hex-to-segment font.
package seg7_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_DPMASK = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BLANK  = 2'd3;

  localparam int CTRL_EN_BIT           = 0;
  localparam int CTRL_BRIGHT_LSB       = 4;
  localparam int CTRL_BLANKMASK_EN_BIT = 8;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hexfont(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus between the CPU front-end and the display controller.
interface seg7_scan_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              WE;
  logic [31:0]       datain;
  logic [31:0]       dataout;

  modport master (output address, WE, datain, input dataout);
  modport slave  (input address, WE, datain, output dataout);
endinterface

// File: rtl/seg7_scan_timer.sv
// Slot/phase/digit counters for the display scan, plus the frame-end commit strobe.
module seg7_scan_timer #(
  parameter  int CLK_HZ   = 100_000_000,
  parameter  int FRAME_HZ = 250,
  parameter  int N_DIGITS = 4,
  localparam int DIG_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       phase,
  output logic [DIG_W-1:0] cur_digit,
  output logic             commit
);

  localparam int SLOT_TICKS  = CLK_HZ / (FRAME_HZ * N_DIGITS);
  localparam int PHASE_TICKS = SLOT_TICKS / 16;
  localparam int TICK_W      = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  if (PHASE_TICKS < 1) begin : g_bad_rate
    $error("seg7_scan_timer: slot too short for 16 PWM phases");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_timer: N_DIGITS must be 1..8");
  end

  logic [TICK_W-1:0] tick;
  logic [31:0]       quotient;
  logic              tick_last;
  logic              digit_last;

  assign tick_last  = (tick == TICK_W'(SLOT_TICKS - 1));
  assign digit_last = (cur_digit == DIG_W'(N_DIGITS - 1));
  assign commit     = tick_last & digit_last;

  // Ticks left over after 16 whole phases fold into phase 15.
  always_comb begin
    quotient = 32'(tick) / 32'(PHASE_TICKS);
    phase    = (quotient > 32'd15) ? 4'd15 : quotient[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      cur_digit <= '0;
    end else if (tick_last) begin
      tick      <= '0;
      cur_digit <= digit_last ? '0 : cur_digit + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped N-digit common-anode display controller: shadow registers,
// frame-atomic commit to the active set, and the registered pin driver.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int                N_DIGITS  = 4,
  parameter int                CLK_HZ    = 100_000_000,
  parameter int                FRAME_HZ  = 250,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_ctrl_if.slave     bus,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DATA_W = 4 * N_DIGITS;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [N_DIGITS-1:0] dpmask;
    logic                en;
    logic [3:0]          bright;
    logic                blank_en;
    logic [N_DIGITS-1:0] blank;
  } regset_t;

  logic [3:0]       phase;
  logic [DIG_W-1:0] cur_digit;
  logic             commit;

  seg7_scan_timer #(
    .CLK_HZ   (CLK_HZ),
    .FRAME_HZ (FRAME_HZ),
    .N_DIGITS (N_DIGITS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .cur_digit (cur_digit),
    .commit    (commit)
  );

  regset_t    shadow, shadow_nxt, active;
  logic       pending;
  logic       hit, wr;
  logic [1:0] reg_idx;
  logic [31:0] rd_val;

  assign hit     = (bus.address[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign reg_idx = bus.address[3:2];
  assign wr      = bus.WE & hit;

  // Byte-lane bits and write data above the mapped fields are ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.address[1:0], bus.datain};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shadow_nxt = shadow;
    if (wr) begin
      case (reg_idx)
        REG_DATA:   shadow_nxt.data   = bus.datain[DATA_W-1:0];
        REG_DPMASK: shadow_nxt.dpmask = bus.datain[N_DIGITS-1:0];
        REG_CTRL: begin
          shadow_nxt.en       = bus.datain[CTRL_EN_BIT];
          shadow_nxt.bright   = bus.datain[CTRL_BRIGHT_LSB +: 4];
          shadow_nxt.blank_en = bus.datain[CTRL_BLANKMASK_EN_BIT];
        end
        default:    shadow_nxt.blank  = bus.datain[N_DIGITS-1:0];
      endcase
    end
  end

  // Reads see pre-edge state, so a read racing a write returns the old value.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (reg_idx)
        REG_DATA:   rd_val[DATA_W-1:0]   = shadow.data;
        REG_DPMASK: rd_val[N_DIGITS-1:0] = shadow.dpmask;
        REG_CTRL: begin
          rd_val[CTRL_EN_BIT]           = shadow.en;
          rd_val[CTRL_BRIGHT_LSB +: 4]  = shadow.bright;
          rd_val[CTRL_BLANKMASK_EN_BIT] = shadow.blank_en;
        end
        default: begin
          rd_val[31]             = pending;
          rd_val[16 +: DIG_W]    = cur_digit;
          rd_val[N_DIGITS-1:0]   = shadow.blank;
        end
      endcase
    end
  end

  // NOTE: the register sets are a handful of flops, not a RAM, so they take
  // the async reset; a reset mid-frame must discard uncommitted writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      bus.dataout <= '0;
    end else begin
      shadow      <= shadow_nxt;
      bus.dataout <= rd_val;
      if (commit) begin
        active  <= shadow_nxt;
        pending <= 1'b0;
      end else if (wr) begin
        pending <= 1'b1;
      end
    end
  end

  logic                lit;
  logic [3:0]          nibble;
  logic [N_DIGITS-1:0] an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  always_comb begin
    lit     = active.en && (phase <= active.bright)
              && !(active.blank_en && active.blank[cur_digit]);
    nibble  = 4'(active.data >> {cur_digit, 2'b00});
    an_nxt  = lit ? ~(N_DIGITS'(1) << cur_digit) : '1;
    seg_nxt = lit ? ~hexfont(nibble) : 7'h7F;
    dp_nxt  = ~(lit & active.dpmask[cur_digit]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a frame-arithmetic reference model
// compared every cycle, plus hand-computed checkpoints at known frame positions.
module tb_seg7_scan_ctrl;

  localparam int          N        = 4;
  localparam int          CLK_HZ   = 1600;
  localparam int          FRAME_HZ = 25;
  localparam int          SLOT     = 16;
  localparam int          FRAME    = SLOT * N;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] IDLE     = BASE + 32'hC;

  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                       7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                       7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.ADDR_W(32)) bus ();
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp;

  seg7_scan_ctrl #(
    .N_DIGITS  (N),
    .CLK_HZ    (CLK_HZ),
    .FRAME_HZ  (FRAME_HZ),
    .ADDR_W    (32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position comes from a plain edge count since reset.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpm;
    logic        en;
    logic [3:0]  bright;
    logic        ben;
    logic [3:0]  blank;
  } regs_t;

  regs_t       sh, ac;
  logic        pend;
  int          k;
  int          m_t, m_d;
  logic        m_lit, m_hit;
  logic [1:0]  m_idx;
  logic [3:0]  m_nib;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [31:0] exp_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh = '0; ac = '0; pend = 1'b0; k = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_dout = '0;
    end else begin
      m_t   = k % SLOT;
      m_d   = (k / SLOT) % N;
      m_lit = ac.en && (m_t <= int'(ac.bright)) && !(ac.ben && ac.blank[m_d]);
      m_nib = ac.data[4*m_d +: 4];
      exp_an  = m_lit ? ~(4'b0001 << m_d) : 4'hF;
      exp_seg = m_lit ? ~FONT[m_nib] : 7'h7F;
      exp_dp  = !(m_lit && ac.dpm[m_d]);

      m_hit = (bus.address[31:4] == BASE[31:4]);
      m_idx = bus.address[3:2];
      exp_dout = '0;
      if (m_hit) begin
        case (m_idx)
          2'd0: exp_dout = {16'h0, sh.data};
          2'd1: exp_dout = {28'h0, sh.dpm};
          2'd2: exp_dout = {23'h0, sh.ben, sh.bright, 3'b000, sh.en};
          default: exp_dout = {pend, 12'h0, 3'(m_d), 12'h0, sh.blank};
        endcase
      end
      if (m_hit && bus.WE) begin
        case (m_idx)
          2'd0: sh.data = bus.datain[15:0];
          2'd1: sh.dpm  = bus.datain[3:0];
          2'd2: begin
            sh.en = bus.datain[0]; sh.bright = bus.datain[7:4]; sh.ben = bus.datain[8];
          end
          default: sh.blank = bus.datain[3:0];
        endcase
        pend = 1'b1;
      end
      if (k % FRAME == FRAME - 1) begin
        ac = sh;
        pend = 1'b0;
      end
      k++;
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("dataout", bus.dataout, exp_dout);
    end
  end

  task automatic wait_k(input int pos);
    int n = 0;
    while ((k % FRAME) != pos && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_k: frame position %0d not reached, k=%0d", pos, k);
    end
  endtask

  // Called on a negedge: drives one write cycle, returns on the next negedge.
  task automatic write_now(input logic [1:0] idx, input logic [31:0] value);
    bus.address = BASE + {28'h0, idx, 2'b00};
    bus.datain  = value;
    bus.WE      = 1'b1;
    @(negedge clk);
    bus.WE      = 1'b0;
    bus.address = IDLE;
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    bus.address = IDLE;
    bus.WE      = 1'b0;
    bus.datain  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // Idle after reset: dark, STATUS reads zero in slot 0.
    wait_k(1);
    check("status_after_rst", bus.dataout, 32'h0);
    check("an_after_rst", 32'(an), 32'hF);
    repeat (2 * FRAME) @(negedge clk);

    // Digits A3C1 at full brightness, committed at the frame boundary.
    @(negedge clk);
    write_now(2'd0, 32'h0000_A3C1);
    write_now(2'd2, 32'h0000_00F1);
    @(negedge clk);
    check("pending_pre", 32'(bus.dataout[31]), 32'h1);
    check("dark_pre_commit", 32'(an), 32'hF);
    wait_k(1);
    check("pending_post", 32'(bus.dataout[31]), 32'h0);
    check("slot0_an", 32'(an), 32'hE);
    check("slot0_seg", 32'(seg), 32'h79);
    wait_k(17);
    check("slot1_an", 32'(an), 32'hD);
    check("slot1_seg", 32'(seg), 32'h46);
    wait_k(33);
    check("slot2_an", 32'(an), 32'hB);
    check("slot2_seg", 32'(seg), 32'h30);
    wait_k(49);
    check("slot3_an", 32'(an), 32'h7);
    check("slot3_seg", 32'(seg), 32'h08);

    // BRIGHT=3: four lit clocks per slot.
    @(negedge clk);
    write_now(2'd2, 32'h0000_0031);
    wait_k(1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (an == 4'hE) cnt_a++;
      if (an != 4'hF) cnt_b++;
      @(negedge clk);
    end
    check("bright3_slot0_lit", 32'(cnt_a), 32'd4);
    check("bright3_frame_lit", 32'(cnt_b), 32'd16);

    // DP on digits 0 and 2, digit 1 blanked.
    write_now(2'd1, 32'h0000_0005);
    write_now(2'd2, 32'h0000_01F1);
    write_now(2'd3, 32'h0000_0002);
    wait_k(1);
    cnt_a = 0; cnt_c = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (!dp) cnt_a++;
      if (!dp && i >= 16 && i < 32) cnt_c++;
      if (i == 21) begin
        check("blank_an", 32'(an), 32'hF);
        check("blank_seg", 32'(seg), 32'h7F);
      end
      @(negedge clk);
    end
    check("dp_frame_low", 32'(cnt_a), 32'd32);
    check("dp_slot1_low", 32'(cnt_c), 32'd0);

    // 1111 then 2222 landing on the commit edge: only 2222 ever shows.
    wait_k(10);
    write_now(2'd0, 32'h0000_1111);
    wait_k(FRAME - 1);
    write_now(2'd0, 32'h0000_2222);
    @(negedge clk);
    check("status_commit_edge", bus.dataout, 32'h0000_0002);
    check("seg_2222", 32'(seg), 32'h24);
    check("an_2222", 32'(an), 32'hE);

    // Unmapped data bits, misses, read-during-write.
    @(negedge clk);
    write_now(2'd0, 32'hFFFF_1234);
    bus.address = BASE;
    @(negedge clk);
    check("data_unmapped", bus.dataout, 32'h0000_1234);
    bus.address = BASE + 32'h10;
    bus.datain  = 32'hFFFF_FFFF;
    bus.WE      = 1'b1;
    @(negedge clk);
    check("miss_read", bus.dataout, 32'h0);
    bus.WE      = 1'b0;
    bus.address = BASE;
    @(negedge clk);
    check("data_after_miss", bus.dataout, 32'h0000_1234);
    bus.address = BASE + 32'h8;
    bus.datain  = 32'h0000_00F1;
    bus.WE      = 1'b1;
    @(negedge clk);
    check("rdwr_old", bus.dataout, 32'h0000_01F1);
    bus.WE = 1'b0;
    @(negedge clk);
    check("rdwr_new", bus.dataout, 32'h0000_00F1);
    bus.address = IDLE;

    // Asynchronous reset mid-slot while digit 0 is lit.
    wait_k(5);
    check("lit_before_rst", 32'(an), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_dout", bus.dataout, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.address = BASE + 32'h8;
    repeat (FRAME + 4) @(negedge clk);
    check("ctrl_after_rst", bus.dataout, 32'h0);
    check("dark_after_rst", 32'(an), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
